// File: rtl/wide_mult_pkg.sv
// wide_mult_pkg: shared state encoding, default sizes and index width helper for the wide multiplier.
package wide_mult_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;
  localparam int WIDTH_DEF = 64;
  localparam int CHUNK_DEF = 16;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/wide_mult_chunk_pp.sv
// wide_mult_chunk_pp: combinational WIDTH x CHUNK unsigned partial product.
module wide_mult_chunk_pp #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic [WIDTH-1:0]       a,
  input  logic [CHUNK-1:0]       b,
  output logic [WIDTH+CHUNK-1:0] p
);
  assign p = (WIDTH+CHUNK)'(a) * (WIDTH+CHUNK)'(b);
endmodule

// File: rtl/wide_mult_seq_core.sv
// wide_mult_seq_core: iterative WIDTH x WIDTH multiplier, one CHUNK of b per cycle.
// Define WIDE_MULT_SIGNED_EN for two's complement operands (sign-magnitude around the unsigned core).
module wide_mult_seq_core import wide_mult_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CHUNK = CHUNK_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_data,
  output logic                 busy
);
  localparam int NB = WIDTH / CHUNK;
  localparam int IW = idx_w(NB);
  if (WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("WIDTH must be a multiple of CHUNK");
  end
  state_t               state;
  logic [WIDTH-1:0]     a_q, b_q, a_in, b_in;
  logic [2*WIDTH-1:0]   acc, acc_nx, res;
  logic [IW-1:0]        idx;
  logic [WIDTH+CHUNK-1:0] pp;
  wide_mult_chunk_pp #(.WIDTH(WIDTH), .CHUNK(CHUNK)) u_pp (
    .a(a_q),
    .b(b_q[idx*CHUNK +: CHUNK]),
    .p(pp)
  );
  assign acc_nx = acc + ((2*WIDTH)'(pp) << (idx*CHUNK));
`ifdef WIDE_MULT_SIGNED_EN
  logic neg;
  assign a_in = in_a[WIDTH-1] ? -in_a : in_a;
  assign b_in = in_b[WIDTH-1] ? -in_b : in_b;
  assign res  = neg ? -acc_nx : acc_nx;
  always_ff @(posedge clk)
    if (reset) neg <= 1'b0;
    else if (state == IDLE && in_valid) neg <= in_a[WIDTH-1] ^ in_b[WIDTH-1];
`else
  assign a_in = in_a;
  assign b_in = in_b;
  assign res  = acc_nx;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
      acc       <= '0;
      idx       <= '0;
      a_q       <= '0;
      b_q       <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_q      <= a_in;
          b_q      <= b_in;
          acc      <= '0;
          idx      <= '0;
          state    <= CALC;
          in_ready <= 1'b0;
          busy     <= 1'b1;
        end
        CALC: begin
          acc <= acc_nx;
          idx <= idx + 1'b1;
          if (idx == IW'(NB-1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            out_data  <= res;
          end
        end
        DONE: if (out_ready) begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wide_mult_seq_core.sv
// tb_wide_mult_seq_core: directed and random checks of the multiplier against an arithmetic model.
module tb_wide_mult_seq_core;
  localparam int NB = 4;
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [63:0]  in_a = '0, in_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] out_data;
  logic         busy;
  int errors = 0, checks = 0, cyc = 0;

  wide_mult_seq_core dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] model(input logic [63:0] a, input logic [63:0] b);
`ifdef WIDE_MULT_SIGNED_EN
    logic signed [127:0] sa, sb;
    sa = {{64{a[63]}}, a};
    sb = {{64{b[63]}}, b};
    return sa * sb;
`else
    return {64'd0, a} * {64'd0, b};
`endif
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // issue one operand pair, wait for the product, check latency and value
  task automatic mult(input string tag, input logic [63:0] a, input logic [63:0] b,
                      output logic [127:0] prod);
    int lat;
    for (int n = 0; n < 20 && !in_ready; n++) tick;
    check({tag, "_ready"}, in_ready, 1'b1);
    in_valid = 1'b1; in_a = a; in_b = b;
    tick;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin tick; lat++; end
    check({tag, "_lat"}, lat, NB);
    check({tag, "_model"}, out_data, model(a, b));
    prod = out_data;
  endtask

  initial begin
    logic [127:0] p, held;
    logic [63:0] ra[20], rb[20];
    logic [127:0] expq[$];
    int acc_cyc[$];
    int i, done;
    bit go;
    tick; tick;
    reset = 1'b0;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_out_data", out_data, '0);

    mult("basic", 64'd3, 64'd7, p);
    check("basic_val", p, 128'd21);
    check("basic_busy", busy, 1'b1);
    tick;
    check("basic_ready_back", in_ready, 1'b1);
    check("basic_valid_drop", out_valid, 1'b0);

    mult("max", '1, '1, p);
`ifdef WIDE_MULT_SIGNED_EN
    check("max_val", p, 128'd1);
`else
    check("max_val", p, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
`endif
    tick;

    mult("sign", 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, p);
`ifdef WIDE_MULT_SIGNED_EN
    check("sign_val", p, {{124{1'b1}}, 4'h1});
`else
    check("sign_val", p, 128'h0000_0000_0000_0004_FFFF_FFFF_FFFF_FFF1);
`endif
    tick;

    mult("minneg", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, p);
    tick;

    out_ready = 1'b0;
    mult("bp", 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, held);
    for (int k = 0; k < 10; k++) begin
      in_valid = (k == 3); in_a = 64'd11; in_b = 64'd13;
      tick;
      check("bp_data", out_data, held);
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_valid", out_valid, 1'b1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick;
    check("bp_consumed", out_valid, 1'b0);
    check("bp_in_ready_back", in_ready, 1'b1);
    done = 0;
    for (int k = 0; k < 8; k++) begin
      done += out_valid;
      tick;
    end
    check("bp_no_second", done, 0);

    for (int n = 0; n < 20 && !in_ready; n++) tick;
    in_valid = 1'b1; in_a = 64'd5; in_b = 64'd9;
    tick;
    in_valid = 1'b0;
    tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check("midrst_valid", out_valid, 1'b0);
    check("midrst_ready", in_ready, 1'b1);
    check("midrst_busy", busy, 1'b0);
    mult("after_rst", 64'd2, 64'd2, p);
    check("after_rst_val", p, 128'd4);
    tick;

    for (int k = 0; k < 20; k++) begin
      ra[k] = {$urandom, $urandom};
      rb[k] = {$urandom, $urandom};
    end
    ra[5] = '1; rb[7] = '0; ra[9] = 64'h8000_0000_0000_0000;
    i = 0; done = 0;
    in_a = ra[0]; in_b = rb[0]; in_valid = 1'b1;
    for (int c = 0; c < 400 && done < 20; c++) begin
      if (out_valid) begin
        check($sformatf("stream_%0d", done), out_data, expq.size() ? expq.pop_front() : 'x);
        done++;
      end
      go = in_ready && i < 20;
      if (go) begin
        expq.push_back(model(in_a, in_b));
        if (acc_cyc.size())
          check($sformatf("stream_gap_%0d", i), cyc - acc_cyc[$], NB + 2);
        acc_cyc.push_back(cyc);
        i++;
      end
      tick;
      if (go) begin
        if (i < 20) begin in_a = ra[i]; in_b = rb[i]; end
        else in_valid = 1'b0;
      end
    end
    check("stream_count", done, 20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
